j202_soc_ctrl_wb: RTL

- Wishbone slave control block that sits directly upstream of the j202_soc_core instance in the Caravel user area.
- Owns the core reset (rst_n) and boot-mode (md_boot) signals the core consumes.
- Replaces the raw "register bit 0 drives reset" scheme with a sequenced reset release, a boot-mode override, status/interrupt reporting and an optional watchdog.

---
 rtl/j202_soc_ctrl_wb.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/j202_soc_ctrl_wb.sv
// Wishbone control block owning the j202_soc_core reset (sequenced release) and boot mode.
// Define J202_SOC_CTRL_WB_WDT_EN to build the watchdog that re-holds the core on timeout.
`timescale 1ns/1ps
module j202_soc_ctrl_wb #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [15:0] DLY_RESET = 16'd16,
  parameter int unsigned WDT_W     = 24
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [1:0]  md_boot_pad_i,
  output logic        core_rst_n_o,
  output logic [1:0]  md_boot_o,
  output logic        irq_o
);

  typedef enum logic [1:0] {StIdle = 2'd0, StHold = 2'd1, StRun = 2'd2} state_e;

  localparam logic [1:0] AdrCtrl   = 2'd0;
  localparam logic [1:0] AdrStatus = 2'd1;
  localparam logic [1:0] AdrRstDly = 2'd2;
  localparam logic [1:0] AdrWdt    = 2'd3;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] rst_dly_q, rst_dly_d;
  logic        run_q, run_d;
  logic        restart_q, restart_d;
  logic        ovr_en_q, ovr_en_d;
  logic [1:0]  ovr_val_q, ovr_val_d;
  logic        irq_en_q, irq_en_d;
  logic        done_q, done_d;
  logic        bite_q, bite_d;
  logic [1:0]  boot_run_q, boot_run_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;

  logic             hit, acc, wr;
  logic [1:0]       reg_idx;
  logic             done_set, bite_set;
  logic             wdt_fire;
  logic [WDT_W-1:0] wdt_to_rd;
  logic [1:0]       boot_sel;
  logic [31:0]      rd_data;
  logic             unused_in;

  assign hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign acc     = hit & ~ack_q;
  assign wr      = acc & wbs_we_i;
  assign reg_idx = wbs_adr_i[3:2];

  assign unused_in = ^{wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_sel_i[3:2]};

`ifdef J202_SOC_CTRL_WB_WDT_EN
  logic [WDT_W-1:0] wdt_to_q, wdt_to_d;
  logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;

  assign wdt_fire  = (state_q == StRun) && (wdt_to_q != '0) && (wdt_cnt_q == wdt_to_q);
  assign wdt_to_rd = wdt_to_q;

  always_comb begin
    wdt_to_d = wdt_to_q;
    if (wr && reg_idx == AdrWdt) begin
      for (int b = 0; b < int'(WDT_W); b++) begin
        if (wbs_sel_i[b/8]) wdt_to_d[b] = wbs_dat_i[b];
      end
    end
    wdt_cnt_d = wdt_cnt_q;
    if (state_q == StRun && wdt_to_q != '0) wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
    // Any WDT write is a kick; entering RUN starts a fresh timeout window.
    if (wdt_fire || (wr && reg_idx == AdrWdt) || (state_d == StRun && state_q != StRun)) begin
      wdt_cnt_d = '0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wdt_to_q  <= '0;
      wdt_cnt_q <= '0;
    end else begin
      wdt_to_q  <= wdt_to_d;
      wdt_cnt_q <= wdt_cnt_d;
    end
  end
`else
  assign wdt_fire  = 1'b0;
  assign wdt_to_rd = '0;
`endif

  // Sequencer: run and restart act one edge after the bus write that sets them.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_set = 1'b0;
    bite_set = 1'b0;
    case (state_q)
      StIdle: begin
        if (run_q) begin
          state_d = StHold;
          cnt_d   = rst_dly_q;
        end
      end
      StHold: begin
        if (!run_q) begin
          state_d = StIdle;
        end else if (restart_q) begin
          cnt_d = rst_dly_q;
        end else if (cnt_q == '0) begin
          state_d  = StRun;
          done_set = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StRun: begin
        if (!run_q) begin
          state_d = StIdle;
        end else if (wdt_fire) begin
          state_d  = StHold;
          cnt_d    = rst_dly_q;
          bite_set = 1'b1;
        end else if (restart_q) begin
          state_d = StHold;
          cnt_d   = rst_dly_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    run_d     = run_q;
    restart_d = 1'b0;
    ovr_en_d  = ovr_en_q;
    ovr_val_d = ovr_val_q;
    irq_en_d  = irq_en_q;
    rst_dly_d = rst_dly_q;
    if (wr && reg_idx == AdrCtrl) begin
      if (wbs_sel_i[0]) begin
        run_d     = wbs_dat_i[0];
        restart_d = wbs_dat_i[1];
        ovr_en_d  = wbs_dat_i[2];
        ovr_val_d = wbs_dat_i[4:3];
      end
      if (wbs_sel_i[1]) irq_en_d = wbs_dat_i[8];
    end
    if (wr && reg_idx == AdrRstDly) begin
      if (wbs_sel_i[0]) rst_dly_d[7:0]  = wbs_dat_i[7:0];
      if (wbs_sel_i[1]) rst_dly_d[15:8] = wbs_dat_i[15:8];
    end
    // Set beats a simultaneous write-1-to-clear.
    done_d = done_set | (done_q & ~(wr && reg_idx == AdrStatus && wbs_sel_i[1] && wbs_dat_i[8]));
    bite_d = bite_set | (bite_q & ~(wr && reg_idx == AdrStatus && wbs_sel_i[1] && wbs_dat_i[9]));
  end

  always_comb begin
    rd_data = '0;
    case (reg_idx)
      AdrCtrl: begin
        rd_data[0]   = run_q;
        rd_data[2]   = ovr_en_q;
        rd_data[4:3] = ovr_val_q;
        rd_data[8]   = irq_en_q;
      end
      AdrStatus: begin
        rd_data[1:0] = state_q;
        rd_data[2]   = (state_q == StRun);
        rd_data[8]   = done_q;
        rd_data[9]   = bite_q;
      end
      AdrRstDly: rd_data[15:0] = rst_dly_q;
      default:   rd_data[WDT_W-1:0] = wdt_to_rd;
    endcase
  end

  assign ack_d      = acc;
  assign dat_d      = acc ? rd_data : '0;
  assign boot_sel   = ovr_en_q ? ovr_val_q : md_boot_pad_i;
  assign boot_run_d = (state_q == StHold && state_d == StRun) ? boot_sel : boot_run_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rst_dly_q  <= DLY_RESET;
      run_q      <= 1'b0;
      restart_q  <= 1'b0;
      ovr_en_q   <= 1'b0;
      ovr_val_q  <= '0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      bite_q     <= 1'b0;
      boot_run_q <= '0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rst_dly_q  <= rst_dly_d;
      run_q      <= run_d;
      restart_q  <= restart_d;
      ovr_en_q   <= ovr_en_d;
      ovr_val_q  <= ovr_val_d;
      irq_en_q   <= irq_en_d;
      done_q     <= done_d;
      bite_q     <= bite_d;
      boot_run_q <= boot_run_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
    end
  end

  assign wbs_ack_o    = ack_q;
  assign wbs_dat_o    = dat_q;
  assign core_rst_n_o = (state_q == StRun);
  assign md_boot_o    = (state_q == StRun) ? boot_run_q : boot_sel;
  assign irq_o        = irq_en_q & (done_q | bite_q);

endmodule
